// File: rtl/dbus_pkg.sv
// Shared constants for the SimpleCore data-bus responder: I/O register offsets,
// STATUS/CTRL bit positions and the address-decode select type.
// No logic; imported by dbus_responder and tx_fifo.
package dbus_pkg;

  // Word offsets of the four I/O registers from IO_BASE.
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CYCCNT = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // STATUS layout: [15:8]=0, [7]=ovf, [6]=full, [5]=empty, [4:0]=count.
  localparam int STAT_OVF       = 7;
  localparam int STAT_FULL      = 6;
  localparam int STAT_EMPTY     = 5;
  localparam int STAT_COUNT_LSB = 0;
  localparam int STAT_COUNT_W   = 5;

  // CTRL layout: [0]=ie, everything else reads as zero.
  localparam int CTRL_IE = 0;

  // Result of decoding dAddr; one target per bus cycle.
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_TXDATA,
    SEL_STATUS,
    SEL_CYCCNT,
    SEL_CTRL
  } sel_e;

  // Assemble the STATUS read word from its fields.
  function automatic logic [15:0] pack_status(input logic ovf,
                                              input logic full,
                                              input logic empty,
                                              input logic [STAT_COUNT_W-1:0] count);
    logic [15:0] w;
    w = 16'h0000;
    w[STAT_OVF]   = ovf;
    w[STAT_FULL]  = full;
    w[STAT_EMPTY] = empty;
    w[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
    return w;
  endfunction

endpackage

// File: rtl/dbus_responder_tx_fifo.sv
// Show-ahead transmit FIFO, depth 2^FIFO_AW, 16-bit words.
// Latency: a push is visible at head one cycle later (no bypass); pop takes effect at the edge.
// Backpressure: push while full is dropped and flagged by a one-cycle overflow pulse,
//   unless a pop happens in the same cycle, in which case both proceed.
// Ports: clk/reset (sync, active-high); push/push_data/pop in; head, count, full,
//   empty, overflow and empty_next (empty flag as it will be after this edge) out.
module tx_fifo
  import dbus_pkg::*;
#(
  parameter int FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [15:0]        push_data,
  input  logic               pop,
  output logic [15:0]        head,
  output logic [FIFO_AW:0]   count,
  output logic               full,
  output logic               empty,
  output logic               overflow,
  output logic               empty_next
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW+1)'(DEPTH);

  logic [15:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               push_ok;
  logic               pop_ok;
  logic [FIFO_AW:0]   count_next;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  // A pop frees the slot the simultaneous push needs, so full+pop still accepts.
  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);
  assign overflow = push & full & ~pop_ok;

  always_comb begin
    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // The irq register in the top needs the post-edge empty state.
  assign empty_next = (count_next == '0);

  assign head = empty ? 16'h0000 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  // Storage is not cleared; emptiness is tracked purely by count/pointers.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dbus_responder.sv
// Data-bus responder for the SimpleCore data port: word RAM plus a 4-register I/O page.
// Latency: reads are combinational (zero wait states); writes commit at the rising edge.
// Backpressure: none on the core bus; the TX drain port is valid/ready, and TX pushes
//   into a full FIFO are dropped and latched in the sticky STATUS.ovf bit.
// Ports: clk, reset (sync, active-high); dAddr/nRW from core; dData shared tri-state bus;
//   txData/txValid/txReady drain port; irq = registered (ie & FIFO empty).
module dbus_responder
  import dbus_pkg::*;
#(
  parameter int          RAM_AW  = 8,
  parameter int          FIFO_AW = 2,
  parameter logic [15:0] IO_BASE = 16'hFF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] dAddr,
  inout  wire  [15:0] dData,
  input  logic        nRW,
  output logic [15:0] txData,
  output logic        txValid,
  input  logic        txReady,
  output logic        irq
);

  localparam int RAM_WORDS = 1 << RAM_AW;

  // ---------------------------------------------------------------- decode
  sel_e        sel;
  logic [15:0] io_off;
  logic        ram_hit;
  logic        wr_en;

  // Offset arithmetic means IO_BASE need not be 4-aligned.
  assign io_off  = dAddr - IO_BASE;
  assign ram_hit = ((dAddr >> RAM_AW) == 16'h0000);

  // Reset blocks all writes so a write in flight during reset is discarded.
  assign wr_en = nRW & ~reset;

  always_comb begin
    sel = SEL_NONE;
    if (io_off < 16'd4) begin
      case (io_off[1:0])
        REG_TXDATA: sel = SEL_TXDATA;
        REG_STATUS: sel = SEL_STATUS;
        REG_CYCCNT: sel = SEL_CYCCNT;
        REG_CTRL:   sel = SEL_CTRL;
        default:    sel = SEL_NONE;
      endcase
    end else if (ram_hit) begin
      sel = SEL_RAM;
    end
  end

  // ------------------------------------------------------------------- RAM
  logic [15:0]       ram [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;

  assign ram_idx = dAddr[RAM_AW-1:0];

  // Contents survive reset by design.
  always_ff @(posedge clk) begin
    if (wr_en && sel == SEL_RAM) ram[ram_idx] <= dData;
  end

  // --------------------------------------------------------------- TX FIFO
  logic               fifo_push;
  logic               fifo_pop;
  logic [15:0]        fifo_head;
  logic [FIFO_AW:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_overflow;
  logic               fifo_empty_next;

  assign fifo_push = wr_en & (sel == SEL_TXDATA);
  assign fifo_pop  = txValid & txReady;

  tx_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_tx_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_data  (dData),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .overflow   (fifo_overflow),
    .empty_next (fifo_empty_next)
  );

  assign txValid = ~fifo_empty;
  assign txData  = fifo_head;

  // ------------------------------------------------ STATUS / CYCCNT / CTRL
  logic        ovf;
  logic        ie;
  logic        ie_next;
  logic [15:0] cyccnt;
  logic [15:0] status_word;
  logic [15:0] ctrl_word;

  assign ie_next = (wr_en && sel == SEL_CTRL) ? dData[CTRL_IE] : ie;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf    <= 1'b0;
      ie     <= 1'b0;
      cyccnt <= 16'h0000;
      irq    <= 1'b0;
    end else begin
      // A load replaces this edge's increment; counting resumes from the loaded value.
      if (wr_en && sel == SEL_CYCCNT) cyccnt <= dData;
      else                            cyccnt <= cyccnt + 16'd1;

      // Set and clear come from different addresses, so they never coincide.
      if (fifo_overflow)
        ovf <= 1'b1;
      else if (wr_en && sel == SEL_STATUS && dData[STAT_OVF])
        ovf <= 1'b0;

      ie  <= ie_next;
      irq <= ie_next & fifo_empty_next;
    end
  end

  assign status_word = pack_status(ovf, fifo_full, fifo_empty,
                                   STAT_COUNT_W'(fifo_count));

  always_comb begin
    ctrl_word = 16'h0000;
    ctrl_word[CTRL_IE] = ie;
  end

  // ------------------------------------------------------------- read mux
  logic [15:0] rd_data;

  always_comb begin
    rd_data = 16'h0000;
    case (sel)
      SEL_RAM:    rd_data = ram[ram_idx];
      SEL_STATUS: rd_data = status_word;
      SEL_CYCCNT: rd_data = cyccnt;
      SEL_CTRL:   rd_data = ctrl_word;
      default:    rd_data = 16'h0000;
    endcase
  end

  // The core owns the bus during writes; nobody drives it while in reset.
  assign dData = (!nRW && !reset) ? rd_data : 16'hzzzz;

endmodule
